dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-requester arbiter for the single-port data memory. Shares the memory between
//   the core load/store path (C) and the debug/program-loader port (D). Round-robin
//   grant, one access per cycle, 1-cycle read latency, read data routed back to its owner.
//   Sits between the core/loader and the data_mem SRAM.
// PARAMETERS
//   AW        12  word-address width
//   DW        32  data width (multiple of 8); byte-enable width BW = DW/8
//   LOCK_MAX  4   max consecutive locked grants before forced release (LOCK_EN only)
// PORTS
//   clk      in   1    clock, rising edge
//   reset    in   1    asynchronous, active-high reset
//   c_req    in   1    C access request; C holds c_* stable until c_gnt
//   c_we     in   1    C write (1) / read (0)
//   c_lock   in   1    C requests bus lock (ignored without LOCK_EN)
//   c_addr   in   AW   C word address
//   c_wdata  in   DW   C write data
//   c_be     in   BW   C byte enables
//   c_gnt    out  1    C access issued to memory this cycle
//   c_rvalid out  1    C read data valid
//   c_rdata  out  DW   C read data
//   d_*      --   --   same set for requester D (d_req..d_rdata)
//   m_en     out  1    memory enable
//   m_we     out  1    memory write enable
//   m_addr   out  AW   memory address
//   m_wdata  out  DW   memory write data
//   m_be     out  BW   memory byte enables
//   m_rdata  in   DW   memory read data, valid cycle after m_en & !m_we
// BEHAVIOUR
//   - State regs: last_owner (reset D, so C wins first tie), rd_pend (reset 0),
//     rd_owner (reset C), lock_act (reset 0), lock_owner (reset C), lock_cnt (reset 0).
//   - Reset values: all gnt/rvalid/m_en/m_we 0; m_addr/m_wdata/m_be/rdata 0.
//   - Each cycle select winner: lock_act -> lock_owner if its req, else nobody;
//     one req -> that one; both -> requester != last_owner.
//   - Winner X: x_gnt=1 and m_en=1 combinationally same cycle; m_we/m_addr/m_wdata/m_be
//     mux X fields; last_owner<=X. No winner: m_* all 0.
//   - Read grant: rd_pend<=1, rd_owner<=X; next cycle x_rvalid=1, x_rdata=m_rdata.
//     rdata=0 when rvalid=0. Writes produce no rvalid; complete at grant.
//   - Pipelined: new grant allowed in same cycle a prior read's rvalid is returned;
//     sustained throughput 1 access/cycle, no bubbles.
//   - Fairness: without lock, a waiting req is granted within 1 cycle.
//   - Reset mid-read: pending read dropped; no rvalid after reset release.
//   - Requester dropping req before gnt: allowed; no access issued.
// CONFIGURATION
//   DMEM_ARB_LOCK_EN defined: a grant with x_lock=1 sets lock_act, lock_owner=X,
//     lock_cnt=1; each further locked grant increments lock_cnt. Lock released the
//     cycle owner samples x_lock=0, or when lock_cnt reaches LOCK_MAX (that grant is the
//     last; lock_cnt<=0, other requester has priority next tie). Idle owner with lock
//     held blocks the other requester.
//   DMEM_ARB_LOCK_EN undefined: c_lock/d_lock ignored; lock regs absent; pure round-robin.
// TESTING
//   1. Core-only read c_addr=0x010, m_rdata=0xDEADBEEF -> c_gnt, m_addr=0x010 same cycle;
//      c_rvalid=1, c_rdata=0xDEADBEEF next cycle; d_rvalid stays 0.
//   2. Both req held high 6 cycles after reset -> grants C,D,C,D,C,D; m_en=1 every cycle.
//   3. C write 0x5 be=4'b0011 then D read same addr back-to-back -> m_we 1 then 0,
//      d_rvalid next cycle; no c_rvalid.
//   4. Reset asserted cycle after a read grant -> no rvalid, all outputs 0 during and
//      after reset until next request.
//   5. LOCK_EN, LOCK_MAX=4: D req+lock held, C req held -> D granted 4 cycles, then C;
//      D drops lock after 2 -> C granted on cycle 3.
//   6. LOCK_EN undefined, same stimulus as 5 -> strict C/D alternation.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port data memory between the core (C)
// and the debug/loader port (D). Define DMEM_ARB_LOCK_EN to enable bounded bus locking.
module dmem_arbiter #(
  parameter  int unsigned AW       = 12,
  parameter  int unsigned DW       = 32,
  parameter  int unsigned LOCK_MAX = 4,
  localparam int unsigned BW       = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [BW-1:0] c_be,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [BW-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [BW-1:0] m_be,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic { OWN_C = 1'b0, OWN_D = 1'b1 } owner_e;

  owner_e last_owner_q, last_owner_d;
  owner_e rd_owner_q, rd_owner_d;
  logic   rd_pend_q, rd_pend_d;
  logic   win_vld;
  owner_e win;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned   CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  logic          lock_act_q, lock_act_d;
  owner_e        lock_owner_q, lock_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_nxt;
  logic          lock_live;
  logic          sel_lock;

  // A held lock only takes effect while its owner keeps asserting x_lock.
  assign lock_live = lock_act_q & ((lock_owner_q == OWN_C) ? c_lock : d_lock);
`else
  logic unused_lock;
  assign unused_lock = c_lock ^ d_lock;
`endif

  always_comb begin
    win_vld = 1'b0;
    win     = OWN_C;
    if (!reset) begin
`ifdef DMEM_ARB_LOCK_EN
      if (lock_live) begin
        win     = lock_owner_q;
        win_vld = (lock_owner_q == OWN_C) ? c_req : d_req;
      end else
`endif
      if (c_req && d_req) begin
        win_vld = 1'b1;
        win     = (last_owner_q == OWN_D) ? OWN_C : OWN_D;
      end else if (c_req) begin
        win_vld = 1'b1;
        win     = OWN_C;
      end else if (d_req) begin
        win_vld = 1'b1;
        win     = OWN_D;
      end
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (win_vld) begin
      m_en = 1'b1;
      if (win == OWN_C) begin
        m_we    = c_we;
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_be    = c_be;
      end else begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
      end
    end
  end

  assign c_gnt    = win_vld & (win == OWN_C);
  assign d_gnt    = win_vld & (win == OWN_D);
  assign c_rvalid = rd_pend_q & (rd_owner_q == OWN_C);
  assign d_rvalid = rd_pend_q & (rd_owner_q == OWN_D);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  always_comb begin
    last_owner_d = last_owner_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    if (win_vld) begin
      last_owner_d = win;
      if (!m_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = win;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_D;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_C;
    end else begin
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  // The grant that reaches LOCK_MAX is the last locked one; the lock is then dropped.
  always_comb begin
    lock_act_d   = lock_act_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    lock_cnt_nxt = (lock_live && (win == lock_owner_q)) ? lock_cnt_q + 1'b1 : CW'(1);
    sel_lock     = (win == OWN_C) ? c_lock : d_lock;
    if (win_vld) begin
      if (sel_lock && (lock_cnt_nxt < LOCK_LIM)) begin
        lock_act_d   = 1'b1;
        lock_owner_d = win;
        lock_cnt_d   = lock_cnt_nxt;
      end else begin
        lock_act_d = 1'b0;
        lock_cnt_d = '0;
      end
    end else if (!lock_live) begin
      lock_act_d = 1'b0;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_act_q   <= 1'b0;
      lock_owner_q <= OWN_C;
      lock_cnt_q   <= '0;
    end else begin
      lock_act_q   <= lock_act_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario and randomized checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
  localparam int AW = 12, DW = 32, BW = 4, LMAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr, m_addr;
  logic [DW-1:0] c_wdata, d_wdata, c_rdata, d_rdata, m_wdata, m_rdata;
  logic [BW-1:0] c_be, d_be, m_be;
  logic c_gnt, d_gnt, c_rvalid, d_rvalid, m_en, m_we;

  int tests = 0, fails = 0;

  // behavioural model state: owners are 0 = C, 1 = D, -1 = none
  int mlast, pend_who, lk_on, lk_who, lk_n;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram    [0:(1<<AW)-1];

  int e_win;
  logic e_cg, e_dg, e_men, e_mwe, e_crv, e_drv;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwdata, e_crd, e_drd;
  logic [BW-1:0] e_mbe;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_be(c_be), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  // single-port SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < BW; b++) if (m_be[b]) sram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= sram[m_addr];
      end
    end
  end

  task automatic predict();
    int w;
`ifdef DMEM_ARB_LOCK_EN
    logic ol;
`endif
    #1;
    w = -1;
`ifdef DMEM_ARB_LOCK_EN
    ol = (lk_who == 0) ? c_lock : d_lock;
    if (lk_on != 0 && ol) w = ((lk_who == 0) ? c_req : d_req) ? lk_who : -1;
    else
`endif
    if (c_req && d_req) w = 1 - mlast;
    else if (c_req) w = 0;
    else if (d_req) w = 1;
    e_win    = w;
    e_cg     = (w == 0);
    e_dg     = (w == 1);
    e_men    = (w >= 0);
    e_mwe    = (w == 0) ? c_we    : (w == 1) ? d_we    : 1'b0;
    e_maddr  = (w == 0) ? c_addr  : (w == 1) ? d_addr  : '0;
    e_mwdata = (w == 0) ? c_wdata : (w == 1) ? d_wdata : '0;
    e_mbe    = (w == 0) ? c_be    : (w == 1) ? d_be    : '0;
    e_crv    = (pend_who == 0);
    e_drv    = (pend_who == 1);
    e_crd    = e_crv ? pend_data : '0;
    e_drd    = e_drv ? pend_data : '0;
  endtask

  task automatic commit();
`ifdef DMEM_ARB_LOCK_EN
    int nn;
    logic ol;
    ol = (lk_who == 0) ? c_lock : d_lock;
`endif
    pend_who = -1;
    if (e_win >= 0) begin
      mlast = e_win;
      if (e_mwe) begin
        for (int b = 0; b < BW; b++) if (e_mbe[b]) ref_mem[e_maddr][8*b +: 8] = e_mwdata[8*b +: 8];
      end else begin
        pend_who  = e_win;
        pend_data = ref_mem[e_maddr];
      end
    end
`ifdef DMEM_ARB_LOCK_EN
    if (e_win >= 0) begin
      nn = (lk_on != 0 && ol && e_win == lk_who) ? lk_n + 1 : 1;
      if (((e_win == 0) ? c_lock : d_lock) && nn < LMAX) begin
        lk_on = 1; lk_who = e_win; lk_n = nn;
      end else begin
        lk_on = 0; lk_n = 0;
      end
    end else if (!(lk_on != 0 && ol)) begin
      lk_on = 0; lk_n = 0;
    end
`endif
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0; c_be = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0; d_be = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    mlast = 1; pend_who = -1; lk_on = 0; lk_who = 0; lk_n = 0; e_win = -1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [117:0] outs;
    @(negedge clk);
    idle_inputs();
    reset = 1;
    #1;
    outs = {c_gnt, d_gnt, c_rvalid, d_rvalid, m_en, m_we, m_addr, m_wdata, m_be, c_rdata, d_rdata};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs got=%h want=0", outs); end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      outs = {c_gnt, d_gnt, c_rvalid, d_rvalid, m_en, m_we, m_addr, m_wdata, m_be, c_rdata, d_rdata};
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL post_reset_idle got=%h want=0", outs); end
    end
  endtask

  task automatic test_core_read();
    do_reset();
    sram[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 12'h010; c_be = 4'hF;
    predict();
    tests++;
    if ({c_gnt, d_gnt, m_en, m_we} !== 4'b1010) begin
      fails++; $display("FAIL core_read_gnt got=%b want=1010", {c_gnt, d_gnt, m_en, m_we});
    end
    tests++;
    if (m_addr !== 12'h010) begin fails++; $display("FAIL core_read_addr got=%h want=010", m_addr); end
    commit();
    @(negedge clk);
    c_req = 0;
    predict();
    tests++;
    if ({c_rvalid, d_rvalid} !== 2'b10) begin
      fails++; $display("FAIL core_read_rvalid got=%b want=10", {c_rvalid, d_rvalid});
    end
    tests++;
    if (c_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL core_read_data got=%h want=deadbeef", c_rdata); end
    commit();
  endtask

  task automatic test_alternate();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      c_req = (i < 6); c_addr = 12'h020; d_req = (i < 6); d_addr = 12'h031;
      predict();
      if (i < 6) begin
        tests++;
        if ({c_gnt, d_gnt, m_en} !== {(i % 2 == 0), (i % 2 == 1), 1'b1}) begin
          fails++; $display("FAIL alternate_gnt cycle=%0d got=%b want=%b", i, {c_gnt, d_gnt, m_en},
                            {(i % 2 == 0), (i % 2 == 1), 1'b1});
        end
      end
      tests++;
      if ({c_rvalid, d_rvalid, c_rdata, d_rdata} !== {e_crv, e_drv, e_crd, e_drd}) begin
        fails++; $display("FAIL alternate_rdata cycle=%0d got=%b%b %h %h want=%b%b %h %h", i,
                          c_rvalid, d_rvalid, c_rdata, d_rdata, e_crv, e_drv, e_crd, e_drd);
      end
      commit();
    end
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] wd, old, want;
    do_reset();
    wd  = $urandom;
    old = ref_mem[12'h005];
    want = {old[31:16], wd[15:0]};
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 12'h005; c_wdata = wd; c_be = 4'b0011;
    predict();
    tests++;
    if ({c_gnt, m_en, m_we} !== 3'b111) begin fails++; $display("FAIL wr_grant got=%b want=111", {c_gnt, m_en, m_we}); end
    commit();
    @(negedge clk);
    idle_inputs();
    d_req = 1; d_we = 0; d_addr = 12'h005; d_be = 4'hF;
    predict();
    tests++;
    if ({d_gnt, m_en, m_we, c_rvalid} !== 4'b1100) begin
      fails++; $display("FAIL rd_after_wr got=%b want=1100", {d_gnt, m_en, m_we, c_rvalid});
    end
    commit();
    @(negedge clk);
    d_req = 0;
    predict();
    tests++;
    if ({d_rvalid, c_rvalid, d_rdata} !== {2'b10, want}) begin
      fails++; $display("FAIL rd_after_wr_data got=%b%b %h want=10 %h", d_rvalid, c_rvalid, d_rdata, want);
    end
    commit();
  endtask

  task automatic test_reset_mid_read();
    logic [117:0] outs;
    do_reset();
    @(negedge clk);
    c_req = 1; c_addr = 12'h044;
    predict();
    commit();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    mlast = 1; pend_who = -1; lk_on = 0; lk_n = 0; e_win = -1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset = 0;
      #1;
      outs = {c_gnt, d_gnt, c_rvalid, d_rvalid, m_en, m_we, m_addr, m_wdata, m_be, c_rdata, d_rdata};
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL reset_mid_read cycle=%0d got=%h want=0", i, outs); end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
`ifdef DMEM_ARB_LOCK_EN
    int exp_a [5] = '{1, 1, 1, 1, 0};
    int exp_b [3] = '{1, 1, 0};
`else
    int exp_a [5] = '{1, 0, 1, 0, 1};
    int exp_b [3] = '{1, 0, 1};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_req = 1; d_lock = 1; d_addr = 12'h100; c_req = (i > 0); c_addr = 12'h200;
      predict();
      tests++;
      if ({c_gnt, d_gnt} !== {exp_a[i] == 0, exp_a[i] == 1}) begin
        fails++; $display("FAIL lock_max cycle=%0d got=%b%b want_owner=%0d", i, c_gnt, d_gnt, exp_a[i]);
      end
      commit();
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_req = 1; d_lock = (i < 2); d_addr = 12'h101; c_req = (i > 0); c_addr = 12'h201;
      predict();
      tests++;
      if ({c_gnt, d_gnt} !== {exp_b[i] == 0, exp_b[i] == 1}) begin
        fails++; $display("FAIL lock_drop cycle=%0d got=%b%b want_owner=%0d", i, c_gnt, d_gnt, exp_b[i]);
      end
      commit();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(c_req && e_win != 0) || $urandom_range(9) == 0) begin
        c_req = ($urandom_range(2) != 0); c_we = $urandom_range(1); c_lock = ($urandom_range(3) == 0);
        c_addr = AW'($urandom_range(31)); c_wdata = $urandom; c_be = BW'($urandom);
      end
      if (!(d_req && e_win != 1) || $urandom_range(9) == 0) begin
        d_req = ($urandom_range(2) != 0); d_we = $urandom_range(1); d_lock = ($urandom_range(3) == 0);
        d_addr = AW'($urandom_range(31)); d_wdata = $urandom; d_be = BW'($urandom);
      end
      predict();
      tests++;
      if ({c_gnt, d_gnt, m_en, m_we} !== {e_cg, e_dg, e_men, e_mwe}) begin
        fails++; $display("FAIL rand_gnt cycle=%0d got=%b want=%b", i, {c_gnt, d_gnt, m_en, m_we},
                          {e_cg, e_dg, e_men, e_mwe});
      end
      tests++;
      if ({m_addr, m_wdata, m_be} !== {e_maddr, e_mwdata, e_mbe}) begin
        fails++; $display("FAIL rand_mem cycle=%0d got=%h %h %h want=%h %h %h", i, m_addr, m_wdata, m_be,
                          e_maddr, e_mwdata, e_mbe);
      end
      tests++;
      if ({c_rvalid, d_rvalid, c_rdata, d_rdata} !== {e_crv, e_drv, e_crd, e_drd}) begin
        fails++; $display("FAIL rand_rdata cycle=%0d got=%b%b %h %h want=%b%b %h %h", i,
                          c_rvalid, d_rvalid, c_rdata, d_rdata, e_crv, e_drv, e_crd, e_drd);
      end
      commit();
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    test_reset();
    test_core_read();
    test_alternate();
    test_write_then_read();
    test_reset_mid_read();
    test_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
